// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, even parity, one stop bit.
// Each serial bit is held for BIT_COUNTS clock cycles; all outputs are registered.
module uart_tx #(
   parameter int unsigned BIT_COUNTS = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data,
   input  logic       start,
   output logic       tx_line,
   output logic       busy,
   output logic       finish
);

   localparam int unsigned CNT_W = $clog2(BIT_COUNTS) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_COUNTS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             parity_q, parity_d;
   logic             tx_q, tx_d;
   logic             busy_q, busy_d;
   logic             finish_q, finish_d;
   logic             bit_end;

   assign bit_end = (cnt_q == CNT_LAST);

   // State register; reset forces the line idle-high immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         parity_q <= 1'b0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
         finish_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         parity_q <= parity_d;
         tx_q     <= tx_d;
         busy_q   <= busy_d;
         finish_q <= finish_d;
      end
   end

   // Next-state, datapath and registered-output logic.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      parity_d = parity_q;
      tx_d     = 1'b1;
      busy_d   = 1'b0;
      finish_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d  = S_START;
               shift_d  = data;
               parity_d = ^data;
               bit_d    = '0;
            end
         end
         S_START: begin
            if (bit_end) state_d = S_DATA;
         end
         S_DATA: begin
            if (bit_end) begin
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) begin
                  state_d = S_PARITY;
                  bit_d   = '0;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
         S_PARITY: begin
            if (bit_end) state_d = S_STOP;
         end
         S_STOP: begin
            if (bit_end) begin
               state_d  = S_IDLE;
               finish_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Bit-time counter restarts on every bit boundary and state change.
      if ((state_d != state_q) || bit_end) begin
         cnt_d = '0;
      end else if (state_q != S_IDLE) begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      // Outputs follow the state being entered so they line up with it.
      case (state_d)
         S_IDLE:   tx_d = 1'b1;
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_d[0];
         S_PARITY: tx_d = parity_d;
         S_STOP:   tx_d = 1'b1;
         default:  tx_d = 1'b1;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   assign tx_line = tx_q;
   assign busy    = busy_q;
   assign finish  = finish_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: per-cycle frame checks from a vector table plus
// reset, busy-ignore, back-to-back and mid-frame-reset sequences.
module tb_uart_tx;

   localparam int unsigned B = 5;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] data;
   logic       start;
   logic       tx_line;
   logic       busy;
   logic       finish;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [7:0] data;
      logic       par;   // hand-computed even-parity bit
      bit         hold;  // keep start high into the next frame
      int         inj;   // cycle at which a 0x3C request is injected (0 = none)
   } vec_t;

   vec_t vecs[9];

   uart_tx #(.BIT_COUNTS(B)) dut (
      .clk     (clk),
      .rst     (rst),
      .data    (data),
      .start   (start),
      .tx_line (tx_line),
      .busy    (busy),
      .finish  (finish)
   );

   always #5 clk = ~clk;

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle_check(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk1("idle_tx", tx_line, 1'b1);
         chk1("idle_busy", busy, 1'b0);
         chk1("idle_finish", finish, 1'b0);
      end
   endtask

   // Called at a negedge; start is sampled on the following rising edge (edge 0).
   task automatic run_frame(input vec_t v);
      logic [7:0] rx;
      logic       exp_bit;
      int         slot;
      rx    = '0;
      start = 1'b1;
      data  = v.data;
      @(posedge clk);
      for (int c = 1; c <= int'(11 * B); c++) begin
         @(negedge clk);
         if (c == 1 && !v.hold) start = 1'b0;
         if (c == 1 && v.inj == 0) data = ~v.data;
         if (v.inj != 0 && c == v.inj) begin
            start = 1'b1;
            data  = 8'h3C;
         end
         if (v.inj != 0 && c == v.inj + 1) start = 1'b0;
         slot = (c - 1) / int'(B);
         if (slot == 0)      exp_bit = 1'b0;
         else if (slot <= 8) exp_bit = v.data[slot-1];
         else if (slot == 9) exp_bit = v.par;
         else                exp_bit = 1'b1;
         chk1("frame_tx", tx_line, exp_bit);
         chk1("frame_busy", busy, 1'b1);
         chk1("frame_finish", finish, 1'b0);
         // Receiver-style mid-bit sampling of the data slots.
         if (slot >= 1 && slot <= 8 && ((c - 1) % int'(B)) == int'(B / 2))
            rx[slot-1] = tx_line;
      end
      @(negedge clk);
      chk1("end_finish", finish, 1'b1);
      chk1("end_busy", busy, 1'b0);
      chk1("end_tx_idle", tx_line, 1'b1);
      chk8("rx_word", rx, v.data);
   endtask

   initial begin
      vecs[0] = '{data: 8'hA5, par: 1'b0, hold: 1'b0, inj: 0};
      vecs[1] = '{data: 8'h07, par: 1'b1, hold: 1'b0, inj: 0};
      vecs[2] = '{data: 8'hFF, par: 1'b0, hold: 1'b0, inj: 0};
      vecs[3] = '{data: 8'h00, par: 1'b0, hold: 1'b0, inj: 0};
      vecs[4] = '{data: 8'hA5, par: 1'b0, hold: 1'b0, inj: 20};
      vecs[5] = '{data: 8'h55, par: 1'b0, hold: 1'b1, inj: 0};
      vecs[6] = '{data: 8'h55, par: 1'b0, hold: 1'b0, inj: 0};
      vecs[7] = '{data: 8'h5A, par: 1'b0, hold: 1'b0, inj: 0};
      vecs[8] = '{data: 8'h80, par: 1'b1, hold: 1'b0, inj: 0};

      // Reset held with start asserted: line stays idle.
      rst   = 1'b1;
      start = 1'b1;
      data  = 8'hA5;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk1("rst_tx", tx_line, 1'b1);
         chk1("rst_busy", busy, 1'b0);
         chk1("rst_finish", finish, 1'b0);
      end
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 9; i++) begin
         run_frame(vecs[i]);
         if (!vecs[i].hold) idle_check((vecs[i].inj != 0) ? 20 : 1);
      end

      // Mid-frame reset during data bit 3 of 0x96 (bit 3 is 0).
      start = 1'b1;
      data  = 8'h96;
      @(posedge clk);
      for (int c = 1; c <= 22; c++) begin
         @(negedge clk);
         if (c == 1) start = 1'b0;
      end
      chk1("pre_rst_tx", tx_line, 1'b0);
      rst = 1'b1;
      #1;
      chk1("async_rst_tx", tx_line, 1'b1);
      chk1("async_rst_busy", busy, 1'b0);
      chk1("async_rst_finish", finish, 1'b0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk1("in_rst_finish", finish, 1'b0);
         chk1("in_rst_tx", tx_line, 1'b1);
      end
      rst = 1'b0;
      idle_check(3);
      run_frame('{data: 8'hC3, par: 1'b0, hold: 1'b0, inj: 0});
      idle_check(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
